tl_ul_arb2: RTL and testbench

- Two-master to one-slave TileLink-UL arbiter/scheduler in front of the shared slave A/D port bundle (opcode/param/size/source/address/mask/data/corrupt, valid/ready).
- Round-robin A-channel grant with grant lock while stalled, source-ID tagging, D-channel return routing, per-master outstanding limits, quiesce/idle control for power or clock gating.

---
 rtl/tl_ul_arb2.sv | 222 ++++++++++++++++++++++
 tb/tb_tl_ul_arb2.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_arb2.sv
// Two-master TileLink-UL arbiter onto a single slave A/D port.
// Round-robin A grant held across stalls, source tagging, D routing, outstanding limits.
module tl_ul_arb2 #(
    parameter int SRC_W = 3,
    parameter int OUT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             quiesce,
    output logic             idle,

    input  logic             m0_a_valid,
    output logic             m0_a_ready,
    input  logic [2:0]       m0_a_opcode,
    input  logic [2:0]       m0_a_param,
    input  logic [1:0]       m0_a_size,
    input  logic [SRC_W-1:0] m0_a_source,
    input  logic [31:0]      m0_a_address,
    input  logic [3:0]       m0_a_mask,
    input  logic [31:0]      m0_a_data,
    input  logic             m0_a_corrupt,
    output logic             m0_d_valid,
    input  logic             m0_d_ready,
    output logic [2:0]       m0_d_opcode,
    output logic [1:0]       m0_d_param,
    output logic [1:0]       m0_d_size,
    output logic [SRC_W-1:0] m0_d_source,
    output logic             m0_d_denied,
    output logic             m0_d_corrupt,
    output logic [31:0]      m0_d_data,

    input  logic             m1_a_valid,
    output logic             m1_a_ready,
    input  logic [2:0]       m1_a_opcode,
    input  logic [2:0]       m1_a_param,
    input  logic [1:0]       m1_a_size,
    input  logic [SRC_W-1:0] m1_a_source,
    input  logic [31:0]      m1_a_address,
    input  logic [3:0]       m1_a_mask,
    input  logic [31:0]      m1_a_data,
    input  logic             m1_a_corrupt,
    output logic             m1_d_valid,
    input  logic             m1_d_ready,
    output logic [2:0]       m1_d_opcode,
    output logic [1:0]       m1_d_param,
    output logic [1:0]       m1_d_size,
    output logic [SRC_W-1:0] m1_d_source,
    output logic             m1_d_denied,
    output logic             m1_d_corrupt,
    output logic [31:0]      m1_d_data,

    output logic             s_a_valid,
    input  logic             s_a_ready,
    output logic [2:0]       s_a_opcode,
    output logic [2:0]       s_a_param,
    output logic [1:0]       s_a_size,
    output logic [SRC_W:0]   s_a_source,
    output logic [31:0]      s_a_address,
    output logic [3:0]       s_a_mask,
    output logic [31:0]      s_a_data,
    output logic             s_a_corrupt,
    input  logic             s_d_valid,
    output logic             s_d_ready,
    input  logic [2:0]       s_d_opcode,
    input  logic [1:0]       s_d_param,
    input  logic [1:0]       s_d_size,
    input  logic [SRC_W:0]   s_d_source,
    input  logic             s_d_denied,
    input  logic [31:0]      s_d_data,
    input  logic             s_d_corrupt
);

    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       param;
        logic [1:0]       size;
        logic [SRC_W-1:0] source;
        logic [31:0]      address;
        logic [3:0]       mask;
        logic [31:0]      data;
        logic             corrupt;
    } a_req_t;

    a_req_t [1:0] a_req;
    a_req_t       a_sel;
    logic [1:0]   a_valid;
    logic [1:0]   a_ready;
    logic [1:0]   d_valid;
    logic [1:0]   d_ready;
    logic [1:0]   d_fire;
    logic [1:0]   elig;
    logic [1:0]   cnt_zero;
    logic [1:0]   cnt_full;

    logic rr_ptr_q, rr_ptr_d;
    logic lock_vld_q, lock_vld_d;
    logic lock_idx_q, lock_idx_d;
    logic gnt_vld, gnt_idx;
    logic a_fire;
    logic d_sel;

    assign a_req[0] = {m0_a_opcode, m0_a_param, m0_a_size, m0_a_source,
                       m0_a_address, m0_a_mask, m0_a_data, m0_a_corrupt};
    assign a_req[1] = {m1_a_opcode, m1_a_param, m1_a_size, m1_a_source,
                       m1_a_address, m1_a_mask, m1_a_data, m1_a_corrupt};
    assign a_valid  = {m1_a_valid, m0_a_valid};
    assign d_ready  = {m1_d_ready, m0_d_ready};
    assign elig     = a_valid & ~cnt_full;

    // A held grant wins over everything so a stalled beat is never withdrawn.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr_q;
        if (lock_vld_q) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_idx_q;
        end else if (!quiesce) begin
            if (elig[rr_ptr_q]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_ptr_q;
            end else if (elig[~rr_ptr_q]) begin
                gnt_vld = 1'b1;
                gnt_idx = ~rr_ptr_q;
            end
        end
    end

    assign a_sel       = a_req[gnt_idx];
    assign s_a_valid   = reset_n & gnt_vld & a_valid[gnt_idx];
    assign a_fire      = s_a_valid & s_a_ready;
    assign s_a_opcode  = a_sel.opcode;
    assign s_a_param   = a_sel.param;
    assign s_a_size    = a_sel.size;
    assign s_a_source  = {gnt_idx, a_sel.source};
    assign s_a_address = a_sel.address;
    assign s_a_mask    = a_sel.mask;
    assign s_a_data    = a_sel.data;
    assign s_a_corrupt = a_sel.corrupt;

    assign a_ready[0]  = reset_n & gnt_vld & ~gnt_idx & s_a_ready;
    assign a_ready[1]  = reset_n & gnt_vld &  gnt_idx & s_a_ready;
    assign m0_a_ready  = a_ready[0];
    assign m1_a_ready  = a_ready[1];

    // D return: slave source MSB picks the master, payload is broadcast.
    assign d_sel      = s_d_source[SRC_W];
    assign d_valid[0] = reset_n & s_d_valid & ~d_sel;
    assign d_valid[1] = reset_n & s_d_valid &  d_sel;
    assign d_fire     = d_valid & d_ready;
    assign s_d_ready  = reset_n & d_ready[d_sel];

    assign m0_d_valid   = d_valid[0];
    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[SRC_W-1:0];
    assign m0_d_denied  = s_d_denied;
    assign m0_d_corrupt = s_d_corrupt;
    assign m0_d_data    = s_d_data;
    assign m1_d_valid   = d_valid[1];
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[SRC_W-1:0];
    assign m1_d_denied  = s_d_denied;
    assign m1_d_corrupt = s_d_corrupt;
    assign m1_d_data    = s_d_data;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        if (a_fire) begin
            rr_ptr_d   = ~gnt_idx;
            lock_vld_d = 1'b0;
        end else if (s_a_valid) begin
            lock_vld_d = 1'b1;
            lock_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_cnt
        logic [OUT_W-1:0] cnt_q, cnt_d;
        logic             inc, dec;

        assign inc = a_fire & (gnt_idx == 1'(n));
        assign dec = d_fire[n];

        // An unmatched response never wraps the count below zero.
        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) cnt_d = cnt_q + 1'b1;
            else if (dec && !inc && cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) cnt_q <= '0;
            else          cnt_q <= cnt_d;
        end

        assign cnt_zero[n] = (cnt_q == '0);
        assign cnt_full[n] = &cnt_q;

        a_no_orphan_d: assert property (@(posedge clock) disable iff (!reset_n)
            !(d_fire[n] && cnt_q == '0));
    end

    assign idle = ~lock_vld_q & cnt_zero[0] & cnt_zero[1];

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Bench for tl_ul_arb2: D-routing table, directed corner sequences,
// then randomized traffic against a queue-based model of the arbitration rules.
module tb_tl_ul_arb2;
    localparam int SRC_W = 3;
    localparam int OUT_W = 2;
    localparam int LIMIT = (1 << OUT_W) - 1;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       param;
        logic [1:0]       size;
        logic [SRC_W-1:0] source;
        logic [31:0]      address;
        logic [3:0]       mask;
        logic [31:0]      data;
        logic             corrupt;
    } req_t;

    typedef struct {
        logic           sv;
        logic [SRC_W:0] src;
        logic           r0, r1;
        logic           ev0, ev1, erdy;
    } dvec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic quiesce, idle;

    logic             m0_a_valid, m0_a_ready, m0_a_corrupt;
    logic [2:0]       m0_a_opcode, m0_a_param;
    logic [1:0]       m0_a_size;
    logic [SRC_W-1:0] m0_a_source;
    logic [31:0]      m0_a_address, m0_a_data;
    logic [3:0]       m0_a_mask;
    logic             m0_d_valid, m0_d_ready, m0_d_denied, m0_d_corrupt;
    logic [2:0]       m0_d_opcode;
    logic [1:0]       m0_d_param, m0_d_size;
    logic [SRC_W-1:0] m0_d_source;
    logic [31:0]      m0_d_data;

    logic             m1_a_valid, m1_a_ready, m1_a_corrupt;
    logic [2:0]       m1_a_opcode, m1_a_param;
    logic [1:0]       m1_a_size;
    logic [SRC_W-1:0] m1_a_source;
    logic [31:0]      m1_a_address, m1_a_data;
    logic [3:0]       m1_a_mask;
    logic             m1_d_valid, m1_d_ready, m1_d_denied, m1_d_corrupt;
    logic [2:0]       m1_d_opcode;
    logic [1:0]       m1_d_param, m1_d_size;
    logic [SRC_W-1:0] m1_d_source;
    logic [31:0]      m1_d_data;

    logic             s_a_valid, s_a_ready, s_a_corrupt;
    logic [2:0]       s_a_opcode, s_a_param;
    logic [1:0]       s_a_size;
    logic [SRC_W:0]   s_a_source;
    logic [31:0]      s_a_address, s_a_data;
    logic [3:0]       s_a_mask;
    logic             s_d_valid, s_d_ready, s_d_denied, s_d_corrupt;
    logic [2:0]       s_d_opcode;
    logic [1:0]       s_d_param, s_d_size;
    logic [SRC_W:0]   s_d_source;
    logic [31:0]      s_d_data;

    int nerr = 0;
    int nchk = 0;

    // model state
    req_t             pend [2];
    bit               has  [2];
    logic [SRC_W-1:0] q0[$], q1[$];
    int               mrr;
    bit               mlock;
    int               midx;
    dvec_t            tbl [7];

    tl_ul_arb2 #(.SRC_W(SRC_W), .OUT_W(OUT_W)) dut (
        .clock(clock), .reset_n(reset_n), .quiesce(quiesce), .idle(idle),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_a_corrupt(m0_a_corrupt),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
        .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt), .m0_d_data(m0_d_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_a_corrupt(m1_a_corrupt),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
        .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt), .m1_d_data(m1_d_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_a_corrupt(s_a_corrupt),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_denied(s_d_denied), .s_d_data(s_d_data), .s_d_corrupt(s_d_corrupt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    // A master that was granted but stalled must hold valid and payload.
    logic [1:0]  hold_q = '0;
    logic [31:0] hold_addr [2];
    always @(posedge clock) begin
        if (reset_n && hold_q[0])
            assert (m0_a_valid && m0_a_address == hold_addr[0]) else $error("m0 dropped a stalled request");
        if (reset_n && hold_q[1])
            assert (m1_a_valid && m1_a_address == hold_addr[1]) else $error("m1 dropped a stalled request");
        hold_q[0]    <= reset_n && s_a_valid && !s_a_ready && !s_a_source[SRC_W];
        hold_q[1]    <= reset_n && s_a_valid && !s_a_ready &&  s_a_source[SRC_W];
        hold_addr[0] <= m0_a_address;
        hold_addr[1] <= m1_a_address;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic req_t mk(input logic [31:0] addr, input logic [SRC_W-1:0] src);
        req_t r;
        r = '0;
        r.address = addr;
        r.data    = ~addr;
        r.source  = src;
        r.opcode  = 3'd4;
        r.mask    = 4'hf;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.opcode  = 3'($urandom);
        r.param   = 3'($urandom);
        r.size    = 2'($urandom);
        r.source  = SRC_W'($urandom);
        r.address = $urandom;
        r.mask    = 4'($urandom);
        r.data    = $urandom;
        r.corrupt = 1'($urandom);
        return r;
    endfunction

    task automatic set_a(input int n, input logic v, input req_t r);
        if (n == 0) begin
            m0_a_valid = v; m0_a_opcode = r.opcode; m0_a_param = r.param; m0_a_size = r.size;
            m0_a_source = r.source; m0_a_address = r.address; m0_a_mask = r.mask;
            m0_a_data = r.data; m0_a_corrupt = r.corrupt;
        end else begin
            m1_a_valid = v; m1_a_opcode = r.opcode; m1_a_param = r.param; m1_a_size = r.size;
            m1_a_source = r.source; m1_a_address = r.address; m1_a_mask = r.mask;
            m1_a_data = r.data; m1_a_corrupt = r.corrupt;
        end
    endtask

    task automatic clr();
        set_a(0, 1'b0, '0);
        set_a(1, 1'b0, '0);
        quiesce = 0; s_a_ready = 0;
        s_d_valid = 0; s_d_source = '0; s_d_opcode = '0; s_d_param = '0; s_d_size = '0;
        s_d_denied = 0; s_d_corrupt = 0; s_d_data = '0;
        m0_d_ready = 0; m1_d_ready = 0;
    endtask

    // k D beats to master n, each one firing
    task automatic send_d(input int n, input int k);
        for (int j = 0; j < k; j++) begin
            s_d_valid = 1; s_d_source = {n[0], SRC_W'(j)};
            m0_d_ready = 1; m1_d_ready = 1;
            #1;
            check("d_drain_valid", (n == 0) ? m0_d_valid : m1_d_valid, 1);
            tick();
        end
        s_d_valid = 0; m0_d_ready = 0; m1_d_ready = 0;
    endtask

    initial begin
        int dm, dk, g;
        logic dv, r0, r1, exp_sv;
        logic [SRC_W-1:0] dsrc;
        logic [31:0] dd;

        clr();
        set_a(0, 1'b1, mk(32'h1000_0000, 3'd1));
        s_a_ready = 1; s_d_valid = 1; m0_d_ready = 1;
        #12;
        check("rst_idle", idle, 1);
        check("rst_s_a_valid", s_a_valid, 0);
        check("rst_m0_a_ready", m0_a_ready, 0);
        check("rst_m0_d_valid", m0_d_valid, 0);
        check("rst_s_d_ready", s_d_ready, 0);
        @(posedge clock); #1;
        clr();
        reset_n = 1;

        // D routing table
        tbl[0] = '{1'b1, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            s_d_valid = tbl[i].sv; s_d_source = tbl[i].src;
            m0_d_ready = tbl[i].r0; m1_d_ready = tbl[i].r1;
            s_d_data = 32'hd000_0000 + i;
            #1;
            check("tbl_m0_d_valid", m0_d_valid, tbl[i].ev0);
            check("tbl_m1_d_valid", m1_d_valid, tbl[i].ev1);
            check("tbl_s_d_ready", s_d_ready, tbl[i].erdy);
            check("tbl_m0_d_source", m0_d_source, tbl[i].src[SRC_W-1:0]);
            check("tbl_m1_d_source", m1_d_source, tbl[i].src[SRC_W-1:0]);
            check("tbl_m1_d_data", m1_d_data, 32'hd000_0000 + i);
            s_d_valid = 0;
            tick();
        end
        clr();

        // alternation
        set_a(0, 1'b1, mk(32'h1000_0000, 3'd1));
        set_a(1, 1'b1, mk(32'h2000_0000, 3'd2));
        s_a_ready = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("alt_msb", s_a_source[SRC_W], i % 2);
            check("alt_src", s_a_source[SRC_W-1:0], (i % 2) ? 2 : 1);
            check("alt_ready", (i % 2) ? m1_a_ready : m0_a_ready, 1);
            tick();
        end
        clr();
        check("alt_busy", idle, 0);
        send_d(0, 3);
        send_d(1, 3);
        check("alt_idle", idle, 1);

        // lock against the round-robin preference
        set_a(0, 1'b1, mk(32'h1000_0010, 3'd3)); s_a_ready = 1;
        #1; check("pre_fire", m0_a_ready, 1);
        tick();
        set_a(0, 1'b1, mk(32'h1000_0020, 3'd4)); s_a_ready = 0;
        #1; check("lock_c1_valid", s_a_valid, 1); check("lock_c1_msb", s_a_source[SRC_W], 0);
        tick();
        set_a(1, 1'b1, mk(32'h2000_0020, 3'd5));
        for (int i = 0; i < 2; i++) begin
            #1; check("lock_hold_msb", s_a_source[SRC_W], 0); check("lock_hold_m1_rdy", m1_a_ready, 0);
            tick();
        end
        s_a_ready = 1;
        #1; check("lock_fire_m0", m0_a_ready, 1); check("lock_fire_m1", m1_a_ready, 0);
        check("lock_fire_addr", s_a_address, 32'h1000_0020);
        tick();
        set_a(0, 1'b0, '0);
        #1; check("lock_next_msb", s_a_source[SRC_W], 1); check("lock_next_m1_rdy", m1_a_ready, 1);
        tick();
        clr();
        send_d(0, 2);
        send_d(1, 1);
        check("lock_idle", idle, 1);

        // outstanding limit
        set_a(1, 1'b1, mk(32'h2000_0100, 3'd6)); s_a_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1; check("lim_fill", m1_a_ready, 1);
            tick();
        end
        set_a(0, 1'b1, mk(32'h1000_0100, 3'd0));
        #1; check("lim_m1_blocked", m1_a_ready, 0); check("lim_m0_rdy", m0_a_ready, 1);
        check("lim_msb", s_a_source[SRC_W], 0);
        tick();
        set_a(0, 1'b0, '0);
        s_d_valid = 1; s_d_source = 4'b1010; m1_d_ready = 1;
        #1; check("lim_no_grant", s_a_valid, 0); check("lim_m1_rdy0", m1_a_ready, 0);
        tick();
        s_d_valid = 0; m1_d_ready = 0;
        #1; check("lim_release", m1_a_ready, 1); check("lim_release_msb", s_a_source[SRC_W], 1);
        tick();
        clr();
        send_d(1, 3);
        send_d(0, 1);
        check("lim_idle", idle, 1);

        // A-fire and D-fire to m0 in one cycle
        set_a(0, 1'b1, mk(32'h1000_0200, 3'd1)); s_a_ready = 1;
        #1; check("same_first", m0_a_ready, 1);
        tick();
        s_d_valid = 1; s_d_source = 4'b0011; m0_d_ready = 1;
        #1; check("same_a", m0_a_ready, 1); check("same_d", m0_d_valid, 1);
        tick();
        clr();
        #1; check("same_idle0", idle, 0);
        send_d(0, 1);
        check("same_idle1", idle, 1);

        // quiesce while locked
        set_a(1, 1'b1, mk(32'h2000_0300, 3'd2)); s_a_ready = 1;
        #1; check("q_m1_fire", m1_a_ready, 1);
        tick();
        set_a(1, 1'b0, '0);
        set_a(0, 1'b1, mk(32'h1000_0300, 3'd3)); s_a_ready = 0;
        #1; check("q_lock_set", s_a_valid, 1);
        tick();
        quiesce = 1;
        set_a(1, 1'b1, mk(32'h2000_0310, 3'd4));
        #1; check("q_lock_keeps", s_a_valid, 1); check("q_lock_msb", s_a_source[SRC_W], 0);
        tick();
        s_a_ready = 1;
        #1; check("q_lock_fire", m0_a_ready, 1);
        tick();
        set_a(0, 1'b1, mk(32'h1000_0310, 3'd5));
        for (int i = 0; i < 3; i++) begin
            s_d_valid = (i != 0); s_d_source = (i == 1) ? 4'b0001 : 4'b1001;
            m0_d_ready = 1; m1_d_ready = 1;
            #1;
            check("q_no_grant", s_a_valid, 0);
            check("q_m0_rdy", m0_a_ready, 0);
            check("q_m1_rdy", m1_a_ready, 0);
            tick();
        end
        clr();
        #1; check("q_idle", idle, 1);

        // randomized traffic vs model; rr preference is 1 after the last m0 fire
        mrr = 1; mlock = 0; midx = 0; has[0] = 0; has[1] = 0;
        for (int cyc = 0; cyc < 430; cyc++) begin
            for (int n = 0; n < 2; n++)
                if (cyc < 400 && !has[n] && $urandom_range(0, 2) != 0) begin
                    has[n] = 1; pend[n] = rand_req();
                end
            quiesce   = (cyc < 400) && ($urandom_range(0, 7) == 0);
            s_a_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
            set_a(0, has[0], has[0] ? pend[0] : '0);
            set_a(1, has[1], has[1] ? pend[1] : '0);
            dv = 0; dm = 0; dk = 0; dsrc = SRC_W'($urandom);
            if (q0.size() + q1.size() > 0 && $urandom_range(0, 1) == 1) begin
                if (q0.size() == 0) dm = 1;
                else if (q1.size() == 0) dm = 0;
                else dm = $urandom_range(0, 1);
                if (dm == 0) begin dk = $urandom_range(0, q0.size() - 1); dsrc = q0[dk]; end
                else begin dk = $urandom_range(0, q1.size() - 1); dsrc = q1[dk]; end
                dv = 1;
            end
            r0 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 3) != 0);
            dd = $urandom;
            s_d_valid = dv; s_d_source = {dm[0], dsrc}; m0_d_ready = r0; m1_d_ready = r1;
            s_d_data = dd;

            g = -1;
            if (mlock) g = midx;
            else if (!quiesce) begin
                bit e0, e1;
                e0 = has[0] && q0.size() < LIMIT;
                e1 = has[1] && q1.size() < LIMIT;
                if (mrr == 0) g = e0 ? 0 : (e1 ? 1 : -1);
                else          g = e1 ? 1 : (e0 ? 0 : -1);
            end
            exp_sv = (g >= 0) && has[g];
            #1;
            check("rnd_s_a_valid", s_a_valid, exp_sv);
            if (exp_sv) begin
                check("rnd_s_a_source", s_a_source, {g[0], pend[g].source});
                check("rnd_s_a_data", s_a_data, pend[g].data);
            end
            check("rnd_m0_a_ready", m0_a_ready, (g == 0) && s_a_ready);
            check("rnd_m1_a_ready", m1_a_ready, (g == 1) && s_a_ready);
            check("rnd_m0_d_valid", m0_d_valid, dv && dm == 0);
            check("rnd_m1_d_valid", m1_d_valid, dv && dm == 1);
            check("rnd_s_d_ready", s_d_ready, dm[0] ? r1 : r0);
            check("rnd_d_data", m1_d_data, dd);
            check("rnd_idle", idle, !mlock && q0.size() == 0 && q1.size() == 0);

            if (dv && (dm[0] ? r1 : r0)) begin
                if (dm == 0) q0.delete(dk); else q1.delete(dk);
            end
            if (exp_sv && s_a_ready) begin
                if (g == 0) q0.push_back(pend[0].source); else q1.push_back(pend[1].source);
                has[g] = 0; mrr = 1 - g; mlock = 0;
            end else if (exp_sv) begin
                mlock = 1; midx = g;
            end
            tick();
        end
        check("rnd_drained", has[0] || has[1], 0);
        clr();

        // D to m0 stalled by m0, then async reset mid-burst
        set_a(0, 1'b1, mk(32'h1000_0400, 3'd2));
        s_a_ready = 0;
        s_d_valid = 1; s_d_source = 4'b0101; m0_d_ready = 0; m1_d_ready = 1;
        #1;
        check("burst_m0_d_valid", m0_d_valid, 1);
        check("burst_m0_d_source", m0_d_source, 3'b101);
        check("burst_m1_d_valid", m1_d_valid, 0);
        check("burst_s_d_ready", s_d_ready, 0);
        tick();
        check("pre_rst_idle", idle, 0);
        #3;
        reset_n = 0;
        #1;
        check("arst_s_a_valid", s_a_valid, 0);
        check("arst_m0_a_ready", m0_a_ready, 0);
        check("arst_m0_d_valid", m0_d_valid, 0);
        check("arst_m1_d_valid", m1_d_valid, 0);
        check("arst_s_d_ready", s_d_ready, 0);
        check("arst_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
